image_rx_loader: RTL and testbench

//  Upstream feeder for the CNN inference core. Takes a framed byte stream from the UART RX,

---
 rtl/image_rx_loader.sv | 131 +++++++++++++
 tb/tb_image_rx_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_rx_loader.sv
// Frames UART bytes (SYNC0, SYNC1, IMG_SIZE pixels) into the image RAM, then starts inference
// and waits for done. Bytes arriving while inference is pending are dropped and flagged.
module image_rx_loader #(
    parameter int          IMG_SIZE    = 784,
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  SYNC0       = 8'hAA,
    parameter logic [7:0]  SYNC1       = 8'h55,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter int          TO_W        = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              img_wr_en,
    output logic [ADDR_W-1:0] img_wr_addr,
    output logic [7:0]        img_wr_data,
    output logic              infer_start,
    input  logic              infer_done,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LOAD,
        S_START,
        S_WAIT_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_SIZE - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [TO_W-1:0]   to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pix_cnt     <= '0;
            to_cnt      <= '0;
            img_wr_en   <= 1'b0;
            img_wr_addr <= '0;
            img_wr_data <= '0;
            infer_start <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            img_wr_en   <= 1'b0;
            infer_start <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SYNC0) begin
                        state   <= S_SYNC;
                        busy    <= 1'b1;
                        overrun <= 1'b0;
                        to_cnt  <= '0;
                    end
                end
                S_SYNC: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        if (rx_data == SYNC1) begin
                            state   <= S_LOAD;
                            pix_cnt <= '0;
                        end else if (rx_data != SYNC0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (rx_valid) begin
                        img_wr_en   <= 1'b1;
                        img_wr_addr <= pix_cnt;
                        img_wr_data <= rx_data;
                        to_cnt      <= '0;
                        if (pix_cnt == LAST_PIX) begin
                            state <= S_START;
                        end else begin
                            pix_cnt <= pix_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_START: begin
                    infer_start <= 1'b1;
                    state       <= S_WAIT_DONE;
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    // infer_start is still high on the first WAIT_DONE cycle; it masks a stale done
                    if (infer_done && !infer_start) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Inter-byte watchdog, only while a frame header or body is in flight
            if ((state == S_SYNC || state == S_LOAD) && !rx_valid) begin
                if (to_cnt == TO_LAST) begin
                    frame_err <= 1'b1;
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_image_rx_loader.sv
// Bench for image_rx_loader: random framed traffic against a golden image and frame counter.
module tb_image_rx_loader;

    localparam int         IMG    = 64;
    localparam int         AW     = 10;
    localparam int         TO_CYC = 200;
    localparam int         TOW    = 8;
    localparam logic [7:0] S0     = 8'hAA;
    localparam logic [7:0] S1     = 8'h55;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          img_wr_en;
    logic [AW-1:0] img_wr_addr;
    logic [7:0]    img_wr_data;
    logic          infer_start;
    logic          infer_done;
    logic          busy;
    logic          frame_err;
    logic          overrun;
    logic [7:0]    frame_count;

    image_rx_loader #(
        .IMG_SIZE(IMG), .ADDR_W(AW), .SYNC0(S0), .SYNC1(S1),
        .TIMEOUT_CYC(TO_CYC), .TO_W(TOW)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .infer_start(infer_start), .infer_done(infer_done), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;

    logic [7:0] ram  [0:IMG-1];
    logic [7:0] gold [0:IMG-1];
    int cyc = 0, frm_wr = 0, addr_bad = 0, last_wr_cyc = 0;
    int start_cnt = 0, start_cyc = 0, ferr_cnt = 0, ferr_cyc = 0;

    // RAM model and event recorder
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (img_wr_en) begin
            if (int'(img_wr_addr) != frm_wr || int'(img_wr_addr) >= IMG) addr_bad = addr_bad + 1;
            else ram[img_wr_addr] = img_wr_data;
            frm_wr = frm_wr + 1;
            last_wr_cyc = cyc;
        end
        if (infer_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic load_frame(input bit ramp, input bit dbl_sync, input int gap_max);
        int s0, to, nbad;
        s0 = start_cnt;
        frm_wr = 0;
        addr_bad = 0;
        for (int i = 0; i < IMG; i++) gold[i] = ramp ? 8'(i) : 8'($urandom);
        send_byte(S0, $urandom_range(gap_max, 0));
        if (dbl_sync) send_byte(S0, $urandom_range(gap_max, 0));
        send_byte(S1, $urandom_range(gap_max, 0));
        for (int i = 0; i < IMG; i++) send_byte(gold[i], (i == IMG-1) ? 0 : $urandom_range(gap_max, 0));
        to = 0;
        while (start_cnt == s0 && to < 20) begin
            @(posedge clk);
            #1 to++;
        end
        total++; if (start_cnt != s0 + 1) begin bad++; $display("FAIL start_pulse: got %0d pulses, want 1", start_cnt - s0); end
        total++; if (frm_wr != IMG) begin bad++; $display("FAIL wr_count: got %0d, want %0d", frm_wr, IMG); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL addr_seq: %0d out-of-order writes, want 0", addr_bad); end
        total++; if (start_cyc != last_wr_cyc + 1) begin bad++; $display("FAIL start_timing: start cyc %0d, want %0d", start_cyc, last_wr_cyc + 1); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b, want 1", busy); end
        nbad = 0;
        for (int i = 0; i < IMG; i++) if (ram[i] !== gold[i]) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL ram_image: %0d bytes differ, want 0", nbad); end
    endtask

    task automatic finish_frame();
        @(negedge clk) infer_done = 1'b1;
        @(negedge clk) infer_done = 1'b0;
        exp_fc = (exp_fc + 1) % 256;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_done: got %b, want 0", busy); end
        total++; if (frame_count !== 8'(exp_fc)) begin bad++; $display("FAIL frame_count: got %0d, want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; infer_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({img_wr_en, infer_start, busy, frame_err, overrun} !== 5'b0 || frame_count !== 8'd0 ||
            img_wr_addr !== '0 || img_wr_data !== 8'd0) begin
            bad++; $display("FAIL reset_state: en=%b st=%b busy=%b err=%b ovr=%b fc=%0d, want all 0",
                            img_wr_en, infer_start, busy, frame_err, overrun, frame_count);
        end
        @(negedge clk) rst = 1'b0;
        exp_fc = 0;
    endtask

    task automatic test_basic_frame();
        load_frame(1'b1, 1'b0, 2);
        finish_frame();
    endtask

    task automatic test_sync_variants();
        load_frame(1'b0, 1'b1, 1);
        finish_frame();
        frm_wr = 0;
        send_byte(S0, 0);
        send_byte(8'h12, 2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_sync1: busy %b, want 0", busy); end
        total++; if (frm_wr != 0) begin bad++; $display("FAIL bad_sync1_writes: %0d, want 0", frm_wr); end
    endtask

    task automatic test_timeout();
        int f0, s0, to, dt;
        f0 = ferr_cnt; s0 = start_cnt; frm_wr = 0; addr_bad = 0;
        send_byte(S0, 0);
        send_byte(S1, 1);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), $urandom_range(2, 0));
        to = 0;
        while (ferr_cnt == f0 && to < TO_CYC + 20) begin
            @(posedge clk);
            #1 to++;
        end
        dt = ferr_cyc - last_wr_cyc;
        total++; if (ferr_cnt != f0 + 1) begin bad++; $display("FAIL timeout_pulse: got %0d pulses, want 1", ferr_cnt - f0); end
        total++; if (dt < TO_CYC - 1 || dt > TO_CYC + 1) begin bad++; $display("FAIL timeout_delay: got %0d cycles, want about %0d", dt, TO_CYC); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy %b, want 0", busy); end
        total++; if (start_cnt != s0) begin bad++; $display("FAIL timeout_start: %0d starts, want 0", start_cnt - s0); end
        total++; if (frm_wr != 40) begin bad++; $display("FAIL timeout_writes: %0d, want 40", frm_wr); end
        load_frame(1'b0, 1'b0, 1);
        finish_frame();
    endtask

    task automatic test_overrun();
        int w0;
        load_frame(1'b0, 1'b0, 1);
        w0 = frm_wr;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(1, 0));
        total++; if (frm_wr != w0) begin bad++; $display("FAIL overrun_writes: %0d extra, want 0", frm_wr - w0); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b, want 1", overrun); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL overrun_busy: got %b, want 1", busy); end
        finish_frame();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b, want 1", overrun); end
        send_byte(S0, 0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b, want 0", overrun); end
        send_byte(8'h12, 1);
        // byte coincident with done: done wins, byte is not reused as SYNC0
        load_frame(1'b0, 1'b0, 1);
        @(negedge clk);
        infer_done = 1'b1; rx_valid = 1'b1; rx_data = S0;
        @(negedge clk);
        infer_done = 1'b0; rx_valid = 1'b0;
        exp_fc = (exp_fc + 1) % 256;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL collide_busy: got %b, want 0", busy); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL collide_overrun: got %b, want 1", overrun); end
        total++; if (frame_count !== 8'(exp_fc)) begin bad++; $display("FAIL collide_count: got %0d, want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_reset_midframe();
        int s0;
        s0 = start_cnt;
        send_byte(S0, 0);
        send_byte(S1, 0);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), $urandom_range(1, 0));
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({img_wr_en, infer_start, busy, frame_err, overrun} !== 5'b0 || frame_count !== 8'd0 ||
            img_wr_addr !== '0 || img_wr_data !== 8'd0) begin
            bad++; $display("FAIL midframe_reset: en=%b st=%b busy=%b fc=%0d addr=%0d, want all 0",
                            img_wr_en, infer_start, busy, frame_count, img_wr_addr);
        end
        @(negedge clk) rst = 1'b0;
        exp_fc = 0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (start_cnt != s0) begin bad++; $display("FAIL midframe_start: %0d starts, want 0", start_cnt - s0); end
        load_frame(1'b0, 1'b0, 1);
        finish_frame();
    endtask

    task automatic test_done_held();
        @(negedge clk) infer_done = 1'b1;
        load_frame(1'b0, 1'b0, 1);
        @(posedge clk);
        #1;
        exp_fc = (exp_fc + 1) % 256;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_done_exit: busy %b, want 0", busy); end
        total++; if (frame_count !== 8'(exp_fc)) begin bad++; $display("FAIL held_done_count: got %0d, want %0d", frame_count, exp_fc); end
        @(negedge clk) infer_done = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        do begin
            load_frame(1'b0, 1'b0, 0);
            finish_frame();
            n++;
        end while (exp_fc != 0 && n < 300);
        total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL count_wrap: got %0d, want 0", frame_count); end
    endtask

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_sync_variants();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_done_held();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
